multicycle_core: RTL and testbench

- Multi-cycle RV32I-subset core; next generation of the single-cycle top.
- Executes the same instruction subset (lw, sw, R-type ALU, I-type ALU, beq, jal) over several cycles per instruction.
- Uses one shared instruction/data memory port with a ready handshake, so wait-state memory is supported.
- Adds parametrised reset vector, bus timeout, misalignment/illegal traps, a retire strobe and a register debug read port.

---
 rtl/multicycle_core.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core (lw, sw, R/I ALU, beq, jal) on a single shared
// memory port with a ready handshake, bus timeout, traps, retire strobe and debug read.
module multicycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 255,
  parameter int          TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        trap,
  output logic [1:0]  trap_cause,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, ALUWB, JAL, BEQ, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_BUS      = 2'd3;

  localparam int                   TO_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TO_LAST_I[TIMEOUT_W-1:0];

  state_t                 state;
  logic [31:0]            pc, old_pc, ir, a, b, alu_out, mdr;
  logic [TIMEOUT_W-1:0]   wait_cnt;
  logic [31:0]            regs [32];

  // instruction fields
  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic [31:0] rf_rs1, rf_rs2;
  assign rf_rs1    = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rf_rs2    = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

  // memory port is a pure function of state, so addr/we/wdata hold while waiting
  logic mem_state, mem_done, timeout_hit;
  assign mem_state   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign mem_req     = mem_state && !rst;
  assign mem_we      = (state == MEMWRITE);
  assign mem_addr    = (state == FETCH) ? pc : alu_out;
  assign mem_wdata   = b;
  assign mem_done    = mem_req && mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (wait_cnt == TO_LAST);

  assign pc_out = (state == FETCH) ? pc : old_pc;
  assign retire = !rst && ((state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                           (state == JAL) || ((state == MEMWRITE) && mem_ready));

  logic [31:0] addr_sum, br_target;
  assign addr_sum  = a + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign br_target = old_pc + ((opcode == OP_BRANCH) ? imm_b : imm_j);

  // ALU shared by EXEC_R / EXEC_I; alu_ok flags unsupported encodings
  logic [31:0] alu_b, alu_res;
  logic        alu_ok;
  assign alu_b = (state == EXEC_R) ? b : imm_i;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (f3)
      3'b000:  alu_res = (state == EXEC_R && f7[5]) ? a - alu_b : a + alu_b;
      3'b111:  alu_res = a & alu_b;
      3'b110:  alu_res = a | alu_b;
      3'b010:  alu_res = {31'b0, ($signed(a) < $signed(alu_b))};
      default: alu_ok  = 1'b0;
    endcase
    if (state == EXEC_R && !(f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'b000)))
      alu_ok = 1'b0;
  end

  logic        rf_we;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    case (state)
      MEMWB:   begin rf_we = 1'b1; rf_wd = mdr;                end
      ALUWB:   begin rf_we = 1'b1; rf_wd = alu_out;            end
      JAL:     begin rf_we = 1'b1; rf_wd = old_pc + 32'd4;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      old_pc     <= RESET_PC;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      alu_out    <= '0;
      mdr        <= '0;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (mem_req)
        wait_cnt <= mem_ready ? '0 : wait_cnt + TIMEOUT_W'(1);

      if (rf_we && rd != 5'd0)
        regs[rd] <= rf_wd;

      case (state)
        FETCH: begin
          if (mem_done) begin
            ir     <= mem_rdata;
            old_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= DECODE;
          end else if (timeout_hit) begin
            old_pc     <= pc;   // report the address whose fetch hung
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_BUS;
          end
        end
        DECODE: begin
          a       <= rf_rs1;
          b       <= rf_rs2;
          alu_out <= br_target;
          if (opcode == OP_LOAD || opcode == OP_STORE) state <= MEMADR;
          else if (opcode == OP_REG)                   state <= EXEC_R;
          else if (opcode == OP_IMM)                   state <= EXEC_I;
          else if (opcode == OP_BRANCH && f3 == 3'b000) state <= BEQ;
          else if (opcode == OP_JAL)                   state <= JAL;
          else begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        MEMADR: begin
          alu_out <= addr_sum;
          if (addr_sum[1:0] != 2'b00) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_MISALIGN;
          end else begin
            state <= (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
          end
        end
        MEMREAD, MEMWRITE: begin
          if (mem_done) begin
            mdr   <= mem_rdata;
            state <= (state == MEMREAD) ? MEMWB : FETCH;
          end else if (timeout_hit) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_BUS;
          end
        end
        MEMWB: state <= FETCH;
        EXEC_R, EXEC_I: begin
          if (alu_ok) begin
            alu_out <= alu_res;
            state   <= ALUWB;
          end else begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        ALUWB: state <= FETCH;
        BEQ: begin
          if (a == b) pc <= alu_out;
          state <= FETCH;
        end
        JAL: begin
          pc    <= alu_out;
          state <= FETCH;
        end
        TRAP:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small word memory with per-word wait states,
// hand-computed register, bus, cycle-count and trap expectations.
module tb_multicycle_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, dbg_rdata;
  logic [1:0]  trap_cause;
  logic [4:0]  dbg_raddr;

  logic [31:0] mem [256];
  int          wt  [256];
  int          cnt;
  int          n_tests, n_fail;

  multicycle_core #(.RESET_PC(32'h100), .MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_out(pc_out), .trap(trap), .trap_cause(trap_cause),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory answers after wt[word] stall cycles of the current transaction
  assign mem_ready = mem_req && (cnt >= wt[mem_addr[9:2]]);
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk or posedge rst) begin
    if (rst)          cnt <= 0;
    else if (mem_req) cnt <= mem_ready ? 0 : cnt + 1;
  end

  function automatic logic [31:0] i_type(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] r_type(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] s_type(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_type(int imm, int rs2, int rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_type(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_raddr = idx[4:0];
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // ticks until retire is seen; n comes back as the tick count (50 = never)
  task automatic wait_retire(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!retire && n < 50);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      wt[i]  = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam int OPI = 7'b0010011;
  localparam int OPL = 7'b0000011;

  initial begin
    int n, bad;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; dbg_raddr = 5'd0;

    // ---------- program 1: ALU, store with waits, x0, jumps, branches, illegal ----------
    clear_mem();
    mem[64] = i_type(5, 0, 0, 1, OPI);         // 0x100 addi x1,x0,5
    mem[65] = i_type(7, 0, 0, 2, OPI);         // 0x104 addi x2,x0,7
    mem[66] = r_type(0, 2, 1, 0, 3);           // 0x108 add  x3,x1,x2
    mem[67] = r_type(32, 2, 1, 0, 4);          // 0x10C sub  x4,x1,x2
    mem[68] = r_type(0, 0, 4, 2, 5);           // 0x110 slt  x5,x4,x0
    mem[69] = s_type(8, 3, 0);                 // 0x114 sw   x3,8(x0)
    mem[70] = i_type(9, 0, 0, 0, OPI);         // 0x118 addi x0,x0,9
    mem[71] = j_type(-220, 0);                 // 0x11C jal  x0,0x40
    mem[16] = j_type(16, 6);                   // 0x40  jal  x6,16
    mem[20] = j_type(-48, 0);                  // 0x50  jal  x0,0x20
    mem[8]  = b_type(-8, 1, 1);                // 0x20  beq  x1,x1,-8
    mem[6]  = b_type(256, 2, 1);               // 0x18  beq  x1,x2,+256 (not taken)
    mem[7]  = 32'h0000_0000;                   // 0x1C  illegal
    wt[2]   = 3;                               // store target 0x8 stalls 3 cycles

    tick(); tick();
    chk("rst_req",   32'(mem_req), 0);
    chk("rst_trap",  32'(trap), 0);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_ret",   32'(retire), 0);
    rst = 1'b0;
    #1;
    chk("boot_req",  32'(mem_req), 1);
    chk("boot_addr", mem_addr, 32'h100);
    chk("boot_we",   32'(mem_we), 0);
    chk("boot_ret",  32'(retire), 0);
    chk("boot_trap", 32'(trap), 0);
    chk("boot_pc",   pc_out, 32'h100);

    wait_retire(n); chk("addi1_cyc", n, 3);    // sampling began inside the first FETCH
    wait_retire(n); chk("addi2_cyc", n, 4);
    wait_retire(n); chk("add_cyc",   n, 4);
    wait_retire(n); chk("sub_cyc",   n, 4);
    wait_retire(n); chk("slt_cyc",   n, 4);
    tick();
    chk("sw_fetch", mem_addr, 32'h114);
    chk_reg("x1", 1, 32'd5);
    chk_reg("x2", 2, 32'd7);
    chk_reg("x3", 3, 32'd12);
    chk_reg("x4", 4, 32'hFFFF_FFFE);
    chk_reg("x5", 5, 32'd1);

    tick(); tick(); tick();                    // DECODE, MEMADR, first MEMWRITE cycle
    for (int i = 0; i < 4; i++) begin
      chk("sw_req",   32'(mem_req), 1);
      chk("sw_we",    32'(mem_we), 1);
      chk("sw_addr",  mem_addr, 32'h8);
      chk("sw_wdata", mem_wdata, 32'd12);
      chk("sw_ret",   32'(retire), (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) tick();
    end
    tick();
    chk("after_sw_addr", mem_addr, 32'h118);
    chk("after_sw_we",   32'(mem_we), 0);
    chk("after_sw_ret",  32'(retire), 0);

    wait_retire(n); chk("addi_x0_cyc", n, 3);
    tick();
    chk_reg("x0", 0, 32'd0);
    chk("jal0_fetch", mem_addr, 32'h11C);
    wait_retire(n); chk("jal0_cyc", n, 2);
    tick();
    chk("jal_fetch", mem_addr, 32'h40);
    chk("jal_pc",    pc_out, 32'h40);
    wait_retire(n); chk("jal_cyc", n, 2);
    tick();
    chk("jal_target", mem_addr, 32'h50);
    chk_reg("x6", 6, 32'h44);
    wait_retire(n); tick();
    chk("beq_fetch", mem_addr, 32'h20);
    wait_retire(n); chk("beq_cyc", n, 2);
    tick();
    chk("beq_taken", mem_addr, 32'h18);
    wait_retire(n); tick();
    chk("beq_not_taken", mem_addr, 32'h1C);
    tick(); tick();
    chk("ill_trap",  32'(trap), 1);
    chk("ill_cause", 32'(trap_cause), 1);
    chk("ill_pc",    pc_out, 32'h1C);
    bad = 0;
    repeat (5) begin
      tick();
      if (mem_req || retire || !trap) bad++;
    end
    chk("ill_quiet", bad, 0);
    rst = 1'b1;
    #1;
    chk("ill_clr_trap",  32'(trap), 0);
    chk("ill_clr_cause", 32'(trap_cause), 0);

    // ---------- program 2: misaligned lw ----------
    clear_mem();
    mem[64] = i_type(2, 0, 2, 1, OPL);         // 0x100 lw x1,2(x0)
    tick();
    rst = 1'b0;
    #1;
    chk("mis_fetch_req", 32'(mem_req), 1);
    bad = 0;
    repeat (6) begin
      tick();
      if (mem_req || retire) bad++;
    end
    chk("mis_noreq", bad, 0);
    chk("mis_trap",  32'(trap), 1);
    chk("mis_cause", 32'(trap_cause), 2);
    chk("mis_pc",    pc_out, 32'h100);
    rst = 1'b1;
    #1;
    chk("mis_clr", 32'(trap), 0);

    // ---------- program 3: fetch that never completes ----------
    clear_mem();
    mem[64] = i_type(1, 0, 0, 1, OPI);
    wt[64]  = 1000;
    tick();
    rst = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!mem_req || trap || mem_addr != 32'h100) bad++;
      tick();
    end
    chk("to_waiting", bad, 0);
    chk("to_trap",  32'(trap), 1);
    chk("to_cause", 32'(trap_cause), 3);
    chk("to_req",   32'(mem_req), 0);
    chk("to_pc",    pc_out, 32'h100);
    bad = 0;
    repeat (4) begin
      tick();
      if (mem_req || retire) bad++;
    end
    chk("to_quiet", bad, 0);
    rst = 1'b1;
    #1;
    chk("to_clr", 32'(trap), 0);

    // ---------- program 4: loads, then reset during a read stall ----------
    clear_mem();
    mem[64] = i_type(5, 0, 0, 1, OPI);         // 0x100 addi x1,x0,5
    mem[65] = i_type(68, 0, 2, 7, OPL);        // 0x104 lw x7,0x44(x0)
    mem[66] = i_type(64, 0, 2, 2, OPL);        // 0x108 lw x2,0x40(x0)
    mem[17] = 32'hCAFE_F00D;
    mem[16] = 32'h1234_5678;
    wt[16]  = 2;
    tick();
    rst = 1'b0;
    #1;
    wait_retire(n); chk("p4_addi_cyc", n, 3);
    wait_retire(n); chk("lw_cyc", n, 5);
    tick();
    chk_reg("x7_lw", 7, 32'hCAFE_F00D);
    chk_reg("x1_p4", 1, 32'd5);
    tick(); tick(); tick();                    // DECODE, MEMADR, first MEMREAD cycle
    chk("lw_req",  32'(mem_req), 1);
    chk("lw_addr", mem_addr, 32'h40);
    chk("lw_we",   32'(mem_we), 0);
    tick();
    chk("lw_stall", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk_reg("rst_x1", 1, 32'd0);
    chk_reg("rst_x7", 7, 32'd0);
    chk("rst_mid_pc", pc_out, 32'h100);
    tick();
    rst = 1'b0;
    #1;
    chk("restart_req",  32'(mem_req), 1);
    chk("restart_addr", mem_addr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
